// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, parity modes and the
// default line parameters used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake of the UART transmitter (valid/ready with data).
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);
    logic                 TxValid;
    logic [DATA_BITS-1:0] TxData;
    logic                 TxReady;

    modport master (output TxValid, output TxData, input TxReady);
    modport slave  (input TxValid, input TxData, output TxReady);
endinterface

// File: rtl/counter_modulo_n.sv
// Free-running modulo-N counter with enable and asynchronous active-low clear.
module CounterModuloN #(
    parameter  int N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         Clock,
    input  logic         ClearN,
    input  logic         Enable,
    output logic [W-1:0] Q
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= (Q == W'(N - 1)) ? '0 : Q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl_baud.sv
// Baud divider: one tick on the last clock of every serial bit period.
module uart_tx_ctrl_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic Clock,
    input  logic ClearN,
    input  logic Enable,
    input  logic Restart,
    output logic Tick
);

    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] count;

    // Restart comes from a register, so the counter's clear input never glitches.
    CounterModuloN #(.N(CLKS_PER_BIT)) u_count (
        .Clock  (Clock),
        .ClearN (ClearN & ~Restart),
        .Enable (Enable),
        .Q      (count)
    );

    assign Tick = (count == W'(CLKS_PER_BIT - 1)) && Enable;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on a valid/ready handshake and
// serialises it LSB-first with start bit, optional parity and stop bit(s).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = PARITY_MODE_EVEN,
    parameter int STOP_BITS    = 1
) (
    input  logic           Clock,
    input  logic           ClearN,
    uart_tx_ctrl_if.slave  host,
    output logic           TxSerial,
    output logic           TxBusy,
    output logic           TxDone
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] ST_IDLE   = 3'(IDLE);
    localparam logic [2:0] ST_START  = 3'(START);
    localparam logic [2:0] ST_DATA   = 3'(DATA);
    localparam logic [2:0] ST_PARITY = 3'(PARITY);
    localparam logic [2:0] ST_STOP   = 3'(STOP);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 serial_d;
    logic                 done_d;
    logic                 tick;

    // Held in clear while idle; inside a frame every state change lands on the
    // counter wrap, so each state starts with the count at zero.
    uart_tx_ctrl_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .Clock   (Clock),
        .ClearN  (ClearN),
        .Enable  (TxBusy),
        .Restart (~TxBusy),
        .Tick    (tick)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host.TxValid && host.TxReady) begin
                    shift_d   = host.TxData;
                    parity_d  = (^host.TxData) ^ (PARITY_ODD == PARITY_MODE_ODD);
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                // The bit counter is reused to count stop bits.
                if (tick) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is derived from the next state so TxSerial is a flop output.
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
            ST_PARITY: serial_d = parity_d;
            default:   serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            TxSerial     <= 1'b1;
            host.TxReady <= 1'b1;
            TxBusy       <= 1'b0;
            TxDone       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            TxSerial     <= serial_d;
            host.TxReady <= (state_d == ST_IDLE);
            TxBusy       <= (state_d != ST_IDLE);
            TxDone       <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: four configurations driven in parallel,
// line-level monitors compare every frame against a queue of expected bytes.
module tb_uart_tx_ctrl;

    localparam int NI = 4;

    function automatic int cpb_of(input int u);
        return (u == 3) ? 2 : 4;
    endfunction
    function automatic int db_of(input int u);
        return (u == 3) ? 5 : 8;
    endfunction
    function automatic int pe_of(input int u);
        return (u == 1 || u == 2) ? 1 : 0;
    endfunction
    function automatic int po_of(input int u);
        return (u == 2) ? 1 : 0;
    endfunction
    function automatic int sb_of(input int u);
        return (u == 2) ? 2 : 1;
    endfunction

    // Expected level of each bit cell: start, data LSB first, parity, stops.
    function automatic logic [15:0] frame_bits(input logic [7:0] b, input int u);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < db_of(u); i++) f[1 + i] = b[i];
        if (pe_of(u) != 0) f[1 + db_of(u)] = ($countones(b) % 2 == 1) ^ (po_of(u) != 0);
        return f;
    endfunction

    logic       clk;
    logic       rst_n  [NI];
    logic       valid  [NI];
    logic [7:0] data   [NI];
    logic       ready  [NI];
    logic       serial [NI];
    logic       busy   [NI];
    logic       done   [NI];
    logic [7:0] exp_q  [NI][$];
    bit         mon_busy [NI];
    int         last_gap [NI];

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gen_u
        localparam int CPB = cpb_of(g);
        localparam int DB  = db_of(g);
        localparam int F   = (1 + DB + pe_of(g) + sb_of(g)) * CPB;

        uart_tx_ctrl_if #(.DATA_BITS(DB)) bus ();

        assign bus.TxValid = valid[g];
        assign bus.TxData  = data[g][DB-1:0];
        assign ready[g]    = bus.TxReady;

        uart_tx_ctrl #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY_EN    (pe_of(g)),
            .PARITY_ODD   (po_of(g)),
            .STOP_BITS    (sb_of(g))
        ) dut (
            .Clock    (clk),
            .ClearN   (rst_n[g]),
            .host     (bus),
            .TxSerial (serial[g]),
            .TxBusy   (busy[g]),
            .TxDone   (done[g])
        );

        initial begin : monitor
            int          k, gap;
            bit          in_frame, post, cell_bad, ctl_bad;
            logic [15:0] bits;
            logic [7:0]  b;
            k = 0; gap = 0; in_frame = 0; post = 0; cell_bad = 0; ctl_bad = 0;
            bits = '1; b = '0;
            forever begin
                @(negedge clk);
                if (!rst_n[g]) begin
                    if (in_frame)
                        check($sformatf("u%0d abort serial/busy/done", g),
                              {29'd0, serial[g], busy[g], done[g]}, 32'b100);
                    in_frame = 0; post = 0; gap = 0;
                end else if (post) begin
                    check($sformatf("u%0d done cycle done/busy/ready/serial", g),
                          {28'd0, done[g], busy[g], ready[g], serial[g]}, 32'b1011);
                    post = 0;
                    gap  = 1;
                end else begin
                    if (!in_frame) begin
                        check($sformatf("u%0d idle done", g), {31'd0, done[g]}, 32'd0);
                        if (serial[g] == 1'b0) begin
                            check($sformatf("u%0d frame expected", g),
                                  {31'd0, exp_q[g].size() != 0}, 32'd1);
                            if (exp_q[g].size() != 0) begin
                                b        = exp_q[g].pop_front();
                                bits     = frame_bits(b, g);
                                in_frame = 1;
                                k        = 0;
                                last_gap[g] = gap;
                                cell_bad = 0;
                                ctl_bad  = 0;
                            end
                        end else begin
                            gap++;
                        end
                    end
                    if (in_frame) begin
                        if (serial[g] !== bits[k / CPB]) cell_bad = 1;
                        if ({busy[g], ready[g], done[g]} !== 3'b100) ctl_bad = 1;
                        if (k % CPB == CPB - 1) begin
                            check($sformatf("u%0d byte %0h cell %0d line (1=wrong)", g, b, k / CPB),
                                  {31'd0, cell_bad}, 32'd0);
                            cell_bad = 0;
                        end
                        k++;
                        if (k == F) begin
                            check($sformatf("u%0d byte %0h busy/ready/done in frame (1=wrong)", g, b),
                                  {31'd0, ctl_bad}, 32'd0);
                            in_frame = 0;
                            post     = 1;
                        end
                    end
                end
                mon_busy[g] = in_frame || post;
            end
        end
    end

    // Offers a byte, waits (bounded) for acceptance and queues the expected frame.
    task automatic send(input int u, input logic [7:0] b, input bit keep);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        data[u]  = b;
        valid[u] = 1'b1;
        @(negedge clk);
        while (!ready[u] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d ready before timeout", u), {31'd0, ready[u]}, 32'd1);
        if (!ready[u]) begin
            valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q[u].push_back(b & 8'((1 << db_of(u)) - 1));
        #1;
        if (!keep) valid[u] = 1'b0;
        @(negedge clk);
        check($sformatf("u%0d start latency serial/busy", u), {30'd0, serial[u], busy[u]}, 32'b01);
    endtask

    task automatic random_traffic(input int u, input int n);
        bit keep;
        keep = 0;
        for (int i = 0; i < n; i++) begin
            if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
            keep = ($urandom_range(0, 1) == 1) && (i < n - 1);
            send(u, 8'($urandom), keep);
        end
    endtask

    initial begin : stimulus
        bit idle;
        for (int u = 0; u < NI; u++) begin
            rst_n[u] = 1'b0;
            valid[u] = 1'b0;
            data[u]  = '0;
            last_gap[u] = 0;
        end
        #12;
        for (int u = 0; u < NI; u++)
            check($sformatf("u%0d reset serial/ready/busy/done", u),
                  {28'd0, serial[u], ready[u], busy[u], done[u]}, 32'b1100);
        repeat (3) @(negedge clk);
        for (int u = 0; u < NI; u++) rst_n[u] = 1'b1;

        fork
            begin
                send(0, 8'hA5, 0);
                send(0, 8'h55, 0);
                repeat (12) @(posedge clk);
                #1;
                data[0]  = 8'hFF;
                valid[0] = 1'b1;
                @(negedge clk);
                check("u0 ready low mid frame", {31'd0, ready[0]}, 32'd0);
                send(0, 8'hFF, 0);
                send(0, 8'h0F, 0);
                repeat (15) @(posedge clk);
                #2;
                rst_n[0] = 1'b0;
                #1;
                check("u0 async reset serial/busy/done", {29'd0, serial[0], busy[0], done[0]}, 32'b100);
                repeat (3) begin
                    @(negedge clk);
                    check("u0 no done in reset", {31'd0, done[0]}, 32'd0);
                end
                rst_n[0] = 1'b1;
                send(0, 8'h81, 0);
            end
            begin
                send(1, 8'hA5, 0);
                send(1, 8'h07, 0);
            end
            begin
                send(2, 8'hA5, 0);
                send(2, 8'h3C, 1);
                send(2, 8'hC3, 0);
                @(negedge clk);
                check("u2 back-to-back idle gap", 32'(last_gap[2]), 32'd1);
            end
            begin
                send(3, 8'h1F, 0);
            end
        join

        fork
            random_traffic(0, 6);
            random_traffic(1, 6);
            random_traffic(2, 6);
            random_traffic(3, 6);
        join

        idle = 0;
        for (int c = 0; c < 4000 && !idle; c++) begin
            @(negedge clk);
            #1;
            idle = 1;
            for (int u = 0; u < NI; u++)
                if (exp_q[u].size() != 0 || mon_busy[u]) idle = 0;
        end
        check("all frames drained", {31'd0, idle}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
